// File: rtl/line_fill_responder.sv
// Instruction-cache line-fill responder: on a line read request, streams
// BEATS word reads to a fixed-latency backing RAM, packs the returned words
// into one line and presents it with a single-cycle line_valid pulse.
module line_fill_responder #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int BEATS   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      mem_read,
  input  logic [ADDR_W-1:0]         mem_addr,
  output logic [BEATS*WORD_W-1:0]   mem_data,
  output logic                      line_valid,
  output logic                      busy,
  output logic                      ram_en,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic [WORD_W-1:0]         ram_rdata
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Low address bits covering one line are dropped to align the request.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * WORD_W / 8 - 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(WORD_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]    recv_cnt_reg, recv_cnt_next;
  logic [MEM_LAT-1:0]  vpipe_reg, vpipe_next;
  logic                line_valid_reg, line_valid_next;
  logic                busy_reg, busy_next;
  logic                ram_en_reg, ram_en_next;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic                capture;

  // A beat's data is on ram_rdata when its valid bit leaves the latency pipe;
  // outside FILL (e.g. leftovers from an aborted fill) it is ignored.
  assign capture = (state_reg == FILL) && vpipe_reg[MEM_LAT-1];

  // Next-state, issue sequencing and receive bookkeeping.
  always_comb begin
    state_next      = state_reg;
    issue_cnt_next  = issue_cnt_reg;
    recv_cnt_next   = recv_cnt_reg;
    vpipe_next      = MEM_LAT'({vpipe_reg, ram_en_reg});
    line_valid_next = 1'b0;
    busy_next       = busy_reg;
    ram_en_next     = ram_en_reg;
    ram_addr_next   = ram_addr_reg;
    case (state_reg)
      IDLE: begin
        if (mem_read) begin
          state_next     = FILL;
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
          busy_next      = 1'b1;
          ram_en_next    = 1'b1;
          ram_addr_next  = mem_addr & LINE_MASK;
        end
      end
      FILL: begin
        // Issue side: the address on ram_addr is beat issue_cnt_reg.
        if (ram_en_reg) begin
          if (issue_cnt_reg == LAST_BEAT) begin
            ram_en_next = 1'b0;
          end else begin
            issue_cnt_next = issue_cnt_reg + 1'b1;
            ram_addr_next  = ram_addr_reg + STRIDE;
          end
        end
        // Receive side: last word captured means the line is complete.
        if (capture) begin
          recv_cnt_next = recv_cnt_reg + 1'b1;
          if (recv_cnt_reg == LAST_BEAT) begin
            line_valid_next = 1'b1;
            state_next      = DONE;
          end
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Register all control state; reset aborts any fill in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      issue_cnt_reg  <= '0;
      recv_cnt_reg   <= '0;
      vpipe_reg      <= '0;
      line_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      ram_en_reg     <= 1'b0;
      ram_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      issue_cnt_reg  <= issue_cnt_next;
      recv_cnt_reg   <= recv_cnt_next;
      vpipe_reg      <= vpipe_next;
      line_valid_reg <= line_valid_next;
      busy_reg       <= busy_next;
      ram_en_reg     <= ram_en_next;
      ram_addr_reg   <= ram_addr_next;
    end
  end

  // One register per word slot; untouched slots keep old contents.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic [WORD_W-1:0] word_reg;

    // Capture the returning word when it belongs to this slot.
    always_ff @(posedge CLK) begin
      if (RST) begin
        word_reg <= '0;
      end else if (capture && (recv_cnt_reg == CNT_W'(gi))) begin
        word_reg <= ram_rdata;
      end
    end

    assign mem_data[gi*WORD_W +: WORD_W] = word_reg;
  end

  assign line_valid = line_valid_reg;
  assign busy       = busy_reg;
  assign ram_en     = ram_en_reg;
  assign ram_addr   = ram_addr_reg;

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: two instances (read latency 1 and 3) share
// the request stimulus; each has its own RAM model (word at A reads as A),
// a cycle-based request model feeding a line scoreboard, and a monitor.
module tb_line_fill_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_read;
  logic [31:0] mem_addr;
  int          checks   = 0;
  int          failures = 0;
  bit          tb_done  = 1'b0;

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 1 : 3;

    logic [255:0] mem_data;
    logic         line_valid, busy, ram_en;
    logic [31:0]  ram_addr, ram_rdata;
    logic [31:0]  rd_pipe [L];

    line_fill_responder #(
      .ADDR_W (32),
      .WORD_W (32),
      .BEATS  (8),
      .MEM_LAT(L)
    ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .line_valid(line_valid),
      .busy      (busy),
      .ram_en    (ram_en),
      .ram_addr  (ram_addr),
      .ram_rdata (ram_rdata)
    );

    // RAM model: word at address A holds A; junk on cycles with no read.
    always_ff @(posedge CLK) begin
      rd_pipe[0] <= ram_en ? ram_addr : $urandom();
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[L-1];

    int           edge_n  = 0;
    int           acc     = -1;
    int           free_at = 0;
    logic [31:0]  base_q  = '0;
    bit           started = 1'b0;
    bit           rst_last = 1'b0;
    logic [255:0] exp_q [$];

    // Request model: a request is taken when the responder is free; the
    // whole fill occupies BEATS+L+2 edges before the next can be taken.
    initial begin
      logic [255:0] line;
      forever begin
        @(posedge CLK);
        edge_n++;
        if (RST) begin
          acc      = -1;
          exp_q.delete();
          free_at  = edge_n + 1;
          rst_last = 1'b1;
          started  = 1'b1;
        end else begin
          rst_last = 1'b0;
          if (started && edge_n >= free_at && mem_read === 1'b1) begin
            acc     = edge_n;
            base_q  = {mem_addr[31:5], 5'b0};
            free_at = edge_n + 10 + L;
            for (int i = 0; i < 8; i++) line[32*i +: 32] = base_q + 32'(4 * i);
            exp_q.push_back(line);
          end
        end
      end
    end

    // Monitor: compare outputs against the model mid-cycle.
    initial begin
      int           c;
      bit           en_e, busy_e, lv_e;
      logic [255:0] want;
      forever begin
        @(negedge CLK);
        if (started) begin
          c      = edge_n;
          en_e   = (acc >= 0) && (c <= acc + 7);
          busy_e = (acc >= 0) && (c <= acc + 8 + L);
          lv_e   = (acc >= 0) && (c == acc + 8 + L);
          check($sformatf("L%0d_ram_en@%0d", L, c), 256'(ram_en), 256'(en_e));
          if (en_e)
            check($sformatf("L%0d_ram_addr@%0d", L, c), 256'(ram_addr), 256'(base_q + 32'(4 * (c - acc))));
          check($sformatf("L%0d_busy@%0d", L, c), 256'(busy), 256'(busy_e));
          check($sformatf("L%0d_line_valid@%0d", L, c), 256'(line_valid), 256'(lv_e));
          if (line_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL L%0d_unexpected_line@%0d actual=line_valid expected=no_line", L, c);
            end else begin
              want = exp_q.pop_front();
              check($sformatf("L%0d_line_data@%0d", L, c), mem_data, want);
            end
          end
          if (rst_last) begin
            check($sformatf("L%0d_reset_mem_data@%0d", L, c), mem_data, 256'd0);
            check($sformatf("L%0d_reset_ram_addr@%0d", L, c), 256'(ram_addr), 256'd0);
          end
        end
      end
    end

    // Every accepted request must have produced its line by the end.
    initial begin
      wait (tb_done);
      check($sformatf("L%0d_pending_lines", L), 256'(exp_q.size()), 256'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic req(input logic [31:0] a);
    mem_read = 1'b1;
    mem_addr = a;
    @(negedge CLK);
    mem_read = 1'b0;
    mem_addr = $urandom();
  endtask

  // Stimulus: directed cases first, then a randomized request/reset mix.
  initial begin
    RST      = 1'b1;
    mem_read = 1'b0;
    mem_addr = '0;
    idle(3);
    RST = 1'b0;
    req(32'h0000_0040);
    idle(20);
    req(32'h0000_105F);
    idle(20);
    req(32'h0000_0200);
    idle(20);
    mem_read = 1'b1;
    mem_addr = 32'h0000_1000;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      mem_addr = $urandom();
    end
    mem_read = 1'b0;
    idle(20);
    req(32'h0000_0300);
    idle(3);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    req(32'h0000_0080);
    idle(20);
    req(32'hFFFF_FFE0);
    idle(20);
    req(32'h0000_0000);
    idle(20);
    for (int i = 0; i < 400; i++) begin
      mem_read = ($urandom_range(0, 2) == 0);
      mem_addr = $urandom();
      RST      = ($urandom_range(0, 149) == 0);
      @(negedge CLK);
    end
    RST      = 1'b0;
    mem_read = 1'b0;
    idle(25);
    tb_done = 1'b1;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
